// File: rtl/if_id.sv
// -----------------------------------------------------------------------------
// if_id : instruction buffer between fetch and decode.
//
// A 2-entry FIFO of {instruction, address} pairs. Fetch pushes words while
// the buffer has room; decode consumes the head unless it is stalled. A taken
// jump from execute empties the buffer in one edge, and the word presented by
// fetch in that same cycle is dropped.
//
// When the buffer is empty the outputs present a NOP (addi x0,x0,0) at address
// 0 with inst_valid_o low, so decode always sees a harmless instruction.
//
// Optional feature (macro IF_ID_BYPASS_EN):
//   While the buffer is empty, a valid incoming word is shown on the outputs
//   in the same cycle. If decode is not stalled, the word is consumed straight
//   from the input and never stored. If decode is stalled, the word is stored
//   as usual. Without the macro, every word takes one edge to reach decode.
//
// Ports:
//   clk           in   1   clock, rising edge
//   rst           in   1   asynchronous reset, active high
//   inst_i        in  32   fetched instruction
//   inst_addr_i   in  32   address of inst_i
//   inst_valid_i  in   1   fetch presents a valid instruction
//   inst_ready_o  out  1   buffer accepts a word this cycle (count != 2)
//   hold_flag_i   in   1   decode stalled, head is not consumed
//   jump_flag_i   in   1   taken jump/branch, flush all entries
//   inst_o        out 32   head instruction to decode
//   inst_addr_o   out 32   head instruction address to decode
//   inst_valid_o  out  1   head entry valid
//   level_o       out  2   occupancy, 0..2
// -----------------------------------------------------------------------------
module if_id (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic        inst_valid_i,
    output logic        inst_ready_o,
    input  logic        hold_flag_i,
    input  logic        jump_flag_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o,
    output logic [1:0]  level_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
    } entry_t;

    localparam entry_t EMPTY_ENTRY = '{inst: NOP, addr: 32'h0};

    entry_t     mem [2];
    entry_t     head;
    entry_t     in_entry;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;

    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       bypass;       // outputs show the input word this cycle
    logic       bypass_take;  // decode consumes the input word directly

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign in_entry = '{inst: inst_i, addr: inst_addr_i};
    assign head     = mem[rd_ptr];

    // Ready depends on registered occupancy only. A pop in the same cycle does
    // not make room, so a full buffer always refuses the incoming word.
    assign inst_ready_o = ~full;

`ifdef IF_ID_BYPASS_EN
    // Gated with rst so that the reset output values hold even when fetch
    // is driving a valid word during reset.
    assign bypass      = empty & inst_valid_i & ~jump_flag_i & ~rst;
    assign bypass_take = bypass & ~hold_flag_i;
`else
    assign bypass      = 1'b0;
    assign bypass_take = 1'b0;
`endif

    // A word that decode takes straight from the input is not stored.
    assign push = inst_valid_i & ~full & ~jump_flag_i & ~bypass_take;

    // Pop only stored entries. A bypassed word is never in storage.
    assign pop  = ~empty & ~hold_flag_i & ~jump_flag_i;

    // -------------------------------------------------------------------------
    // State: pointers, occupancy and storage
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= EMPTY_ENTRY;
            mem[1] <= EMPTY_ENTRY;
        end else if (jump_flag_i) begin
            // Flush wins over push and pop. The storage is left as it is,
            // because count == 0 masks it at the outputs.
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;  // idle, or push and pop together
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs to decode
    // -------------------------------------------------------------------------
    always_comb begin
        inst_o       = NOP;
        inst_addr_o  = 32'h0;
        inst_valid_o = 1'b0;
        if (bypass) begin
            inst_o       = inst_i;
            inst_addr_o  = inst_addr_i;
            inst_valid_o = 1'b1;
        end else if (!empty) begin
            inst_o       = head.inst;
            inst_addr_o  = head.addr;
            inst_valid_o = 1'b1;
        end
    end

    assign level_o = count;

    // -------------------------------------------------------------------------
    // Invariants
    // -------------------------------------------------------------------------
    // With two entries and 1-bit pointers, the pointers are equal exactly when
    // the buffer is empty or full.
    a_count_range: assert property (@(posedge clk) disable iff (rst)
        count != 2'd3);
    a_ptr_consistent: assert property (@(posedge clk) disable iff (rst)
        (wr_ptr == rd_ptr) == (count == 2'd0 || count == 2'd2));
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        full |-> !push);

endmodule

// File: tb/tb_if_id.sv
// -----------------------------------------------------------------------------
// tb_if_id : self-checking bench for if_id.
//
// A queue holds the words the buffer should contain. A word is added when the
// bench drives it and the buffer should accept it. A word is removed when the
// buffer presents it and decode is not stalled. On every negative clock edge,
// the outputs of if_id are compared with the head of the queue.
// -----------------------------------------------------------------------------
module tb_if_id;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst_i = '0;
    logic [31:0] inst_addr_i = '0;
    logic        inst_valid_i = 1'b0;
    logic        inst_ready_o;
    logic        hold_flag_i = 1'b0;
    logic        jump_flag_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic [1:0]  level_o;

    ent_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef IF_ID_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    if_id dut (
        .clk          (clk),
        .rst          (rst),
        .inst_i       (inst_i),
        .inst_addr_i  (inst_addr_i),
        .inst_valid_i (inst_valid_i),
        .inst_ready_o (inst_ready_o),
        .hold_flag_i  (hold_flag_i),
        .jump_flag_i  (jump_flag_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o),
        .level_o      (level_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Values if_id must show while it is in reset.
    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".valid"}, 32'(inst_valid_o), 32'd0);
        chk({tag, ".ready"}, 32'(inst_ready_o), 32'd1);
        chk({tag, ".inst"},  inst_o,            NOP);
        chk({tag, ".addr"},  inst_addr_o,       32'h0);
        chk({tag, ".level"}, 32'(level_o),      32'd0);
    endtask

    // Drive one cycle, called just after a rising edge. The bench compares
    // the outputs at the falling edge, then updates the queue at the next
    // rising edge.
    task automatic step(input string tag, input logic v, input logic [31:0] ins,
                        input logic [31:0] adr, input logic hold, input logic jump);
        logic        exp_valid;
        logic [31:0] exp_inst, exp_addr;
        logic        do_push, do_pop, byp;
        int          sz;
        inst_valid_i = v;
        inst_i       = ins;
        inst_addr_i  = adr;
        hold_flag_i  = hold;
        jump_flag_i  = jump;
        @(negedge clk);
        sz  = sb.size();
        byp = BYPASS && sz == 0 && v && !jump;
        if (sz != 0) begin
            exp_valid = 1'b1; exp_inst = sb[0].inst; exp_addr = sb[0].addr;
        end else if (byp) begin
            exp_valid = 1'b1; exp_inst = ins; exp_addr = adr;
        end else begin
            exp_valid = 1'b0; exp_inst = NOP; exp_addr = 32'h0;
        end
        chk({tag, ".valid"}, 32'(inst_valid_o), 32'(exp_valid));
        chk({tag, ".inst"},  inst_o,            exp_inst);
        chk({tag, ".addr"},  inst_addr_o,       exp_addr);
        chk({tag, ".level"}, 32'(level_o),      32'(sz));
        chk({tag, ".ready"}, 32'(inst_ready_o), 32'(sz != 2));
        do_push = v && sz != 2 && !jump && !(byp && !hold);
        do_pop  = sz != 0 && !hold && !jump;
        @(posedge clk);
        if (jump) sb.delete();
        else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back('{inst: ins, addr: adr});
        end
        #1;
    endtask

    initial begin
        // ---- reset: the outputs take their reset values before any clock edge
        #1 rst = 1'b1;
        #2 chk_reset_outputs("rst_async");
        inst_valid_i = 1'b1; inst_i = 32'hDEAD_BEEF; inst_addr_i = 32'h44;
        @(negedge clk); chk_reset_outputs("rst_held");
        inst_valid_i = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // ---- single push, then the word appears one cycle later
        step("push1",  1, 32'h0050_0093, 32'h0, 0, 0);
        step("see1",   0, 32'h0,         32'h0, 0, 0);
        step("idle",   0, 32'h0,         32'h0, 0, 0);

        // ---- stall decode and fill the buffer; a third word is refused
        step("fill_a", 1, 32'h0010_0113, 32'h0, 1, 0);
        step("fill_b", 1, 32'h0020_0193, 32'h4, 1, 0);
        step("full_c", 1, 32'h0030_0213, 32'h8, 1, 0);
        step("full_h", 0, 32'h0,         32'h0, 1, 0);
        // A word is still refused when the head is popped in the same cycle
        step("full_pop", 1, 32'h0030_0213, 32'h8, 0, 0);

        // ---- at level 1, push and pop together: the level stays at 1
        step("pp",     1, 32'h0040_0293, 32'h8, 0, 0);
        step("pp_chk", 0, 32'h0,         32'h0, 1, 0);
        step("drain",  0, 32'h0,         32'h0, 0, 0);
        // Several pushes in a row wrap the pointers and keep the order
        for (int i = 0; i < 6; i++)
            step("wrap", 1, 32'h1000_0000 + 32'(i), 32'(i * 4), 0, 0);
        step("wrap_d", 0, 32'h0, 32'h0, 0, 0);
        step("wrap_e", 0, 32'h0, 32'h0, 0, 0);

        // ---- flush at level 2 with an incoming word that must be dropped
        step("j_a",    1, 32'h0010_0113, 32'h0,  1, 0);
        step("j_b",    1, 32'h0020_0193, 32'h4,  1, 0);
        step("jump",   1, 32'h0060_0313, 32'h10, 0, 1);
        step("j_post", 0, 32'h0,         32'h0,  1, 0);
        step("j_post2",0, 32'h0,         32'h0,  0, 0);

        // ---- reset in the middle of a cycle at level 2
        step("r_a",    1, 32'h0010_0113, 32'h0, 1, 0);
        step("r_b",    1, 32'h0020_0193, 32'h4, 1, 0);
        step("r_lvl2", 0, 32'h0,         32'h0, 1, 0);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("rst_mid");
        sb.delete();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        step("r_post", 0, 32'h0, 32'h0, 0, 0);

        // ---- empty buffer, decode not stalled, a word arrives. With the
        //      bypass feature the word shows at once and is consumed. Without
        //      it, the word is stored first.
        step("byp",    1, 32'h0030_0213, 32'h20, 0, 0);
        step("byp_n",  0, 32'h0,         32'h0,  0, 0);
        step("byp_h",  1, 32'h0040_0213, 32'h24, 1, 0);
        step("byp_h2", 0, 32'h0,         32'h0,  0, 0);
        step("byp_e",  0, 32'h0,         32'h0,  0, 0);

        // ---- random traffic
        for (int i = 0; i < 300; i++)
            step("rnd", 1'($urandom_range(0, 1)), $urandom, 32'(i * 4),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_id.md
IF_ID -- requirements
Module: if_id

Interface
REQ-001 SHALL provide clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL provide inst_i  input  32  fetched instruction word.
REQ-004 SHALL provide inst_addr_i  input  32  address of inst_i.
REQ-005 SHALL provide inst_valid_i  input  1  fetch presents a valid instruction.
REQ-006 SHALL provide inst_ready_o  output  1  buffer accepts an instruction this cycle.
REQ-007 SHALL provide hold_flag_i  input  1  decode stalled; head not consumed.
REQ-008 SHALL provide jump_flag_i  input  1  taken jump/branch from ex; flush all entries.
REQ-009 SHALL provide inst_o  output  32  head instruction to decode.
REQ-010 SHALL provide inst_addr_o  output  32  head instruction address to decode.
REQ-011 SHALL provide inst_valid_o  output  1  head entry valid.
REQ-012 SHALL provide level_o  output  2  occupancy, 0..2.

Function
REQ-013 SHALL be a 2-entry FIFO of {inst, addr} pairs, 1-bit read/write pointers, 2-bit count.
REQ-014 SHALL drive inst_ready_o = (count != 2), registered state only; no combinational path from hold_flag_i or jump_flag_i.
REQ-015 SHALL push when inst_valid_i & inst_ready_o & !jump_flag_i; write at wr_ptr, wr_ptr toggles.
REQ-016 SHALL pop when inst_valid_o & !hold_flag_i & !jump_flag_i; rd_ptr toggles.
REQ-017 SHALL leave count unchanged on simultaneous push and pop, including at count 1.
REQ-018 SHALL, when full, refuse new input even if the head is popped the same cycle.
REQ-019 SHALL, on jump_flag_i=1, set count=0 and wr_ptr=rd_ptr=0 next edge; flush overrides push and pop; the input word that cycle is dropped.
REQ-020 SHALL drive inst_valid_o = (count != 0), and inst_o/inst_addr_o from the entry at rd_ptr.
REQ-021 SHALL, when count==0, drive inst_o=32'h00000013 (NOP), inst_addr_o=32'h0, inst_valid_o=0.
REQ-022 SHALL have latency 1: a word pushed at edge N appears at outputs after edge N.
REQ-023 SHALL keep the head stable while hold_flag_i=1 and no flush.
REQ-024 SHALL drive level_o = count.

Reset
REQ-025 SHALL, while rst=1, immediately force count=0, pointers=0, storage inst=32'h00000013, addr=0.
REQ-026 SHALL, during reset, output inst_valid_o=0, inst_ready_o=1, inst_o=32'h00000013, inst_addr_o=0, level_o=0.
REQ-027 SHALL discard any in-flight contents on reset assertion mid-operation; no partial state survives.

Configuration
REQ-028 SHALL support macro IF_ID_BYPASS_EN.
REQ-029 SHALL, with IF_ID_BYPASS_EN defined and count==0 and inst_valid_i=1 and jump_flag_i=0, present inst_i/inst_addr_i combinationally on outputs with inst_valid_o=1; when hold_flag_i=0 the word is consumed and not stored, otherwise it is pushed.
REQ-030 SHALL, without IF_ID_BYPASS_EN, never bypass; latency strictly per REQ-022.

Verification
REQ-031 SHALL cover: reset, then push inst 0x00500093 @0x0 -> next cycle inst_o=0x00500093, addr_o=0x0, valid_o=1, level_o=1.
REQ-032 SHALL cover: hold_flag_i=1, push 0x00100113 @0x0, 0x00200193 @0x4 -> level_o=2, ready_o=0, head stays 0x00100113; third word @0x8 not accepted.
REQ-033 SHALL cover: level 1, simultaneous push @0x8 and pop -> level_o stays 1, head becomes @0x8; pointer wrap over 4+ pushes keeps order 0x0,0x4,0x8,0xC.
REQ-034 SHALL cover: level 2, jump_flag_i=1 with inst_valid_i=1 @0x10 -> next cycle level_o=0, valid_o=0, inst_o=0x00000013; @0x10 never appears.
REQ-035 SHALL cover: rst asserted mid-cycle at level 2 -> outputs go to reset values without waiting for a clock edge.
REQ-036 SHALL cover (IF_ID_BYPASS_EN): empty, hold=0, push 0x00300213 @0x20 -> same cycle inst_o=0x00300213, valid_o=1; next cycle level_o=0.
